// File: rtl/issue_sel_pkg.sv
// Shared types and defaults for the per-class issue selector.
package issue_sel_pkg;

    localparam int NCOMMIT_DEF  = 32;
    localparam int LNCOMMIT_DEF = $clog2(NCOMMIT_DEF);
    localparam int NUNIT_DEF    = 2;
    localparam int OCC_DEF      = 1;

    typedef logic [LNCOMMIT_DEF-1:0] commit_idx_t;
    typedef logic [NCOMMIT_DEF-1:0]  commit_mask_t;

    typedef enum logic [2:0] {
        UC_ALU,
        UC_SHIFT,
        UC_MUL,
        UC_LOAD,
        UC_STORE,
        UC_FPU
    } unit_class_e;

endpackage

// File: rtl/issue_sel_if.sv
// Bundle between commit-entry ready logic, one issue selector and its unit class.
interface issue_sel_if
    import issue_sel_pkg::*;
#(
    parameter int NCOMMIT = NCOMMIT_DEF,
    parameter int NUNIT   = NUNIT_DEF
);
    localparam int LNCOMMIT = $clog2(NCOMMIT);

    logic [LNCOMMIT-1:0]       start_commit;
    logic [NCOMMIT-1:0]        ready;
    logic [NCOMMIT-1:0]        alloc;
    logic [NCOMMIT-1:0]        kill;
    logic                      flush;
    logic [NUNIT-1:0]          unit_stall;
    logic [NUNIT-1:0]          issue_valid;
    logic [NUNIT*LNCOMMIT-1:0] issue_addr;
    logic [NUNIT-1:0]          unit_busy;

    modport master (
        output start_commit, ready, alloc, kill, flush, unit_stall,
        input  issue_valid, issue_addr, unit_busy
    );

    modport slave (
        input  start_commit, ready, alloc, kill, flush, unit_stall,
        output issue_valid, issue_addr, unit_busy
    );

endinterface

// File: rtl/issue_sel_rot.sv
// Barrel rotate that aligns the eligibility mask so bit 0 is the oldest entry.
module issue_sel_rot
    import issue_sel_pkg::*;
#(
    parameter int N  = NCOMMIT_DEF,
    parameter int LN = $clog2(N)
) (
    input  logic [N-1:0]  in_mask,
    input  logic [LN-1:0] amt,
    output logic [N-1:0]  out_mask
);

    // LN-bit index arithmetic wraps at N because N is a power of two.
    always_comb begin
        out_mask = '0;
        for (int i = 0; i < N; i++) begin
            out_mask[i] = in_mask[amt + LN'(i)];
        end
    end

endmodule

// File: rtl/issue_sel.sv
// Per-class issue selector: grants up to NUNIT oldest eligible commit entries each cycle
// to free units, tracking issued entries and non-pipelined unit occupancy.
module issue_sel
    import issue_sel_pkg::*;
#(
    parameter int NCOMMIT  = NCOMMIT_DEF,
    parameter int LNCOMMIT = $clog2(NCOMMIT),
    parameter int NUNIT    = NUNIT_DEF,
    parameter int OCC      = OCC_DEF
) (
    input logic       clk,
    input logic       reset,
    issue_sel_if.slave bus
);

    localparam int BW = $clog2(OCC + 1);

    logic [NCOMMIT-1:0]                issued_q;
    logic [NUNIT-1:0][BW-1:0]          busy_cnt;
    logic [NCOMMIT-1:0]                elig;
    logic [NCOMMIT-1:0]                rot_elig;
    logic [NUNIT-1:0][NCOMMIT-1:0]     stage_mask;
    logic [NUNIT-1:0]                  pick_found;
    logic [NUNIT-1:0][LNCOMMIT-1:0]    pick_pos;
    logic [NUNIT-1:0]                  unit_free;
    logic [NUNIT-1:0]                  grant;
    logic [NUNIT-1:0][LNCOMMIT-1:0]    grant_addr;
    logic [NCOMMIT-1:0]                grant_mask;

    function automatic logic [LNCOMMIT:0] find_first(input logic [NCOMMIT-1:0] m);
        logic [LNCOMMIT:0] r;
        r = '0;
        for (int i = NCOMMIT - 1; i >= 0; i--) begin
            if (m[i]) r = {1'b1, LNCOMMIT'(i)};
        end
        return r;
    endfunction

    assign elig = bus.flush ? '0 : (bus.ready & ~issued_q & ~bus.kill & ~bus.alloc);

    issue_sel_rot #(.N(NCOMMIT), .LN(LNCOMMIT)) u_rot (
        .in_mask  (elig),
        .amt      (bus.start_commit),
        .out_mask (rot_elig)
    );

    assign stage_mask[0] = rot_elig;

    // Each stage offers its oldest remaining candidate; only a grant consumes it,
    // so a busy or stalled unit passes its candidate on to the next unit.
    for (genvar k = 0; k < NUNIT; k++) begin : g_pick
        assign {pick_found[k], pick_pos[k]} = find_first(stage_mask[k]);
        assign unit_free[k]  = (busy_cnt[k] == '0) & ~bus.unit_stall[k] & ~bus.flush;
        assign grant[k]      = pick_found[k] & unit_free[k];
        assign grant_addr[k] = pick_pos[k] + bus.start_commit;
        assign bus.unit_busy[k] = (busy_cnt[k] != '0);
        if (k < NUNIT - 1) begin : g_next
            assign stage_mask[k+1] = grant[k]
                ? (stage_mask[k] & ~(NCOMMIT'(1) << pick_pos[k]))
                : stage_mask[k];
        end
    end

    always_comb begin
        grant_mask = '0;
        for (int k = 0; k < NUNIT; k++) begin
            if (grant[k]) grant_mask[grant_addr[k]] = 1'b1;
        end
    end

    // Kill/alloc entries are never eligible, so clearing them after the grant OR is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q        <= '0;
            busy_cnt        <= '0;
            bus.issue_valid <= '0;
            bus.issue_addr  <= '0;
        end else begin
            issued_q <= bus.flush ? '0 : ((issued_q | grant_mask) & ~(bus.alloc | bus.kill));
            for (int k = 0; k < NUNIT; k++) begin
                bus.issue_valid[k] <= grant[k];
                if (grant[k]) begin
                    bus.issue_addr[k*LNCOMMIT +: LNCOMMIT] <= grant_addr[k];
                    busy_cnt[k] <= BW'(OCC - 1);
                end else if (bus.flush) begin
                    busy_cnt[k] <= '0;
                end else if (busy_cnt[k] != '0) begin
                    busy_cnt[k] <= busy_cnt[k] - BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_sel.sv
// Drives three issue_sel configurations with shared directed and random stimulus,
// comparing each against an age-ordered queue model.
module tb_issue_sel;

    logic        clk;
    logic        reset;
    logic [4:0]  start_commit;
    logic [31:0] ready;
    logic [31:0] alloc;
    logic [31:0] kill;
    logic        flush;
    logic [3:0]  stall [3];

    int checks = 0;
    int errors = 0;

    int nunit [3] = '{2, 1, 2};
    int occ   [3] = '{1, 3, 4};

    logic [31:0] m_issued [3];
    int          m_busy   [3][4];
    logic [3:0]  e_valid  [3];
    logic [4:0]  e_addr   [3][4];
    logic [3:0]  e_busy   [3];

    issue_sel_if #(.NCOMMIT(32), .NUNIT(2)) if_a ();
    issue_sel_if #(.NCOMMIT(32), .NUNIT(1)) if_b ();
    issue_sel_if #(.NCOMMIT(32), .NUNIT(2)) if_c ();

    issue_sel #(.NCOMMIT(32), .NUNIT(2), .OCC(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    issue_sel #(.NCOMMIT(32), .NUNIT(1), .OCC(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    issue_sel #(.NCOMMIT(32), .NUNIT(2), .OCC(4)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    assign if_a.start_commit = start_commit;
    assign if_a.ready        = ready;
    assign if_a.alloc        = alloc;
    assign if_a.kill         = kill;
    assign if_a.flush        = flush;
    assign if_a.unit_stall   = stall[0][1:0];
    assign if_b.start_commit = start_commit;
    assign if_b.ready        = ready;
    assign if_b.alloc        = alloc;
    assign if_b.kill         = kill;
    assign if_b.flush        = flush;
    assign if_b.unit_stall   = stall[1][0];
    assign if_c.start_commit = start_commit;
    assign if_c.ready        = ready;
    assign if_c.alloc        = alloc;
    assign if_c.kill         = kill;
    assign if_c.flush        = flush;
    assign if_c.unit_stall   = stall[2][1:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] obs_valid(input int inst);
        case (inst)
            0:       return {2'b00, if_a.issue_valid};
            1:       return {3'b000, if_b.issue_valid};
            default: return {2'b00, if_c.issue_valid};
        endcase
    endfunction

    function automatic logic [3:0] obs_busy(input int inst);
        case (inst)
            0:       return {2'b00, if_a.unit_busy};
            1:       return {3'b000, if_b.unit_busy};
            default: return {2'b00, if_c.unit_busy};
        endcase
    endfunction

    function automatic logic [4:0] obs_addr(input int inst, input int k);
        case (inst)
            0:       return (k == 0) ? if_a.issue_addr[4:0] : if_a.issue_addr[9:5];
            1:       return if_b.issue_addr;
            default: return (k == 0) ? if_c.issue_addr[4:0] : if_c.issue_addr[9:5];
        endcase
    endfunction

    // Reference: list eligible entries oldest-first, hand them to free units in order.
    task automatic model_step(input int inst);
        int          q[$];
        int          e;
        logic [31:0] granted;
        bit          free;
        if (reset) begin
            m_issued[inst] = '0;
            e_valid[inst]  = '0;
            e_busy[inst]   = '0;
            for (int k = 0; k < 4; k++) begin
                m_busy[inst][k] = 0;
                e_addr[inst][k] = '0;
            end
            return;
        end
        granted = '0;
        if (!flush) begin
            for (int i = 0; i < 32; i++) begin
                e = (int'(start_commit) + i) % 32;
                if (ready[e] && !m_issued[inst][e] && !kill[e] && !alloc[e]) q.push_back(e);
            end
        end
        for (int k = 0; k < nunit[inst]; k++) begin
            free = (m_busy[inst][k] == 0) && !stall[inst][k] && !flush;
            if (free && q.size() > 0) begin
                e = q.pop_front();
                e_valid[inst][k] = 1'b1;
                e_addr[inst][k]  = 5'(e);
                granted[e]       = 1'b1;
                m_busy[inst][k]  = occ[inst] - 1;
            end else begin
                e_valid[inst][k] = 1'b0;
                if (flush) m_busy[inst][k] = 0;
                else if (m_busy[inst][k] > 0) m_busy[inst][k]--;
            end
            e_busy[inst][k] = (m_busy[inst][k] != 0);
        end
        m_issued[inst] = flush ? '0 : ((m_issued[inst] | granted) & ~(alloc | kill));
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input int inst);
        logic [3:0] ov;
        logic [3:0] ob;
        ov = obs_valid(inst);
        ob = obs_busy(inst);
        for (int k = 0; k < nunit[inst]; k++) begin
            check_value($sformatf("inst%0d valid[%0d]", inst, k), 32'(ov[k]), 32'(e_valid[inst][k]));
            check_value($sformatf("inst%0d addr[%0d]", inst, k), 32'(obs_addr(inst, k)), 32'(e_addr[inst][k]));
            check_value($sformatf("inst%0d busy[%0d]", inst, k), 32'(ob[k]), 32'(e_busy[inst][k]));
        end
    endtask

    task automatic apply_stimulus();
        for (int inst = 0; inst < 3; inst++) model_step(inst);
        @(posedge clk);
        #1;
        for (int inst = 0; inst < 3; inst++) check_output(inst);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start_commit = '0; ready = '0; alloc = '0; kill = '0; flush = 1'b0;
        for (int i = 0; i < 3; i++) stall[i] = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        $display("[TB] start");

        // Power-up reset
        do_reset();
        check_value("reset valid_a", 32'(if_a.issue_valid), 32'h0);
        check_value("reset addr_a", 32'(if_a.issue_addr), 32'h0);
        check_value("reset busy_c", 32'(if_c.unit_busy), 32'h0);

        // Oldest-first with wrap past NCOMMIT-1
        start_commit = 5'd30;
        ready = 32'h8000_0021;
        apply_stimulus();
        check_value("t1 valid", 32'(if_a.issue_valid), 32'h3);
        check_value("t1 addr0", 32'(if_a.issue_addr[4:0]), 32'd31);
        check_value("t1 addr1", 32'(if_a.issue_addr[9:5]), 32'd0);
        apply_stimulus();
        check_value("t1 valid second", 32'(if_a.issue_valid), 32'h1);
        check_value("t1 addr0 second", 32'(if_a.issue_addr[4:0]), 32'd5);
        check_value("t1 addr1 hold", 32'(if_a.issue_addr[9:5]), 32'd0);

        // Non-pipelined unit occupancy
        do_reset();
        ready = 32'h3;
        apply_stimulus();
        check_value("t2 issue e0", {31'd0, if_b.issue_valid}, 32'h1);
        check_value("t2 addr e0", 32'(if_b.issue_addr), 32'd0);
        check_value("t2 busy1", 32'(if_b.unit_busy), 32'h1);
        apply_stimulus();
        check_value("t2 busy2", 32'(if_b.unit_busy), 32'h1);
        check_value("t2 idle2", 32'(if_b.issue_valid), 32'h0);
        apply_stimulus();
        check_value("t2 busy3", 32'(if_b.unit_busy), 32'h0);
        check_value("t2 idle3", 32'(if_b.issue_valid), 32'h0);
        apply_stimulus();
        check_value("t2 issue e1", 32'(if_b.issue_valid), 32'h1);
        check_value("t2 addr e1", 32'(if_b.issue_addr), 32'd1);
        for (int i = 0; i < 6; i++) apply_stimulus();

        // Stalled unit passes its candidate on
        do_reset();
        stall[0] = 4'b0001;
        ready = 32'h80;
        apply_stimulus();
        check_value("t3 valid", 32'(if_a.issue_valid), 32'h2);
        check_value("t3 addr1", 32'(if_a.issue_addr[9:5]), 32'd7);

        // Kill beats grant; alloc re-arms the entry
        do_reset();
        ready = 32'h200;
        kill = 32'h200;
        apply_stimulus();
        check_value("t4 kill no grant", 32'(if_a.issue_valid), 32'h0);
        kill = '0;
        apply_stimulus();
        check_value("t4 first issue", 32'(if_a.issue_valid), 32'h1);
        check_value("t4 first addr", 32'(if_a.issue_addr[4:0]), 32'd9);
        apply_stimulus();
        check_value("t4 no repeat", 32'(if_a.issue_valid), 32'h0);
        alloc = 32'h200;
        apply_stimulus();
        check_value("t4 alloc no grant", 32'(if_a.issue_valid), 32'h0);
        alloc = '0;
        apply_stimulus();
        check_value("t4 reissue", 32'(if_a.issue_valid), 32'h1);
        check_value("t4 reissue addr", 32'(if_a.issue_addr[4:0]), 32'd9);
        apply_stimulus();
        check_value("t4 reissue once", 32'(if_a.issue_valid), 32'h0);

        // Flush while occupied
        do_reset();
        ready = 32'hFF;
        apply_stimulus();
        check_value("t5 first valid", 32'(if_c.issue_valid), 32'h3);
        apply_stimulus();
        check_value("t5 busy", 32'(if_c.unit_busy), 32'h3);
        flush = 1'b1;
        apply_stimulus();
        check_value("t5 flush valid", 32'(if_c.issue_valid), 32'h0);
        check_value("t5 flush busy", 32'(if_c.unit_busy), 32'h0);
        flush = 1'b0;
        apply_stimulus();
        check_value("t5 resume valid", 32'(if_c.issue_valid), 32'h3);
        check_value("t5 resume addr", 32'(if_c.issue_addr), 32'h020);

        // Random traffic, including a mid-stream reset
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset        = ($urandom_range(0, 79) == 0);
            start_commit = 5'($urandom);
            ready        = $urandom | $urandom;
            alloc        = $urandom & $urandom & $urandom;
            kill         = $urandom & $urandom & $urandom;
            flush        = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 3; i++) stall[i] = 4'($urandom & $urandom);
            if (cyc == 300) reset = 1'b1;
            apply_stimulus();
            if (cyc == 300) begin
                check_value("t6 reset valid_c", 32'(if_c.issue_valid), 32'h0);
                check_value("t6 reset busy_b", 32'(if_b.unit_busy), 32'h0);
                check_value("t6 reset addr_c", 32'(if_c.issue_addr), 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
